// File: rtl/text_console_if.sv
// text_console_if: byte-stream input handshake, VRAM write port and cursor outputs of text_console.
// master: producer side (drives char_i/attr_i/valid_i, observes the rest).
// slave:  console side (accepts bytes, drives ready_o, vram_cea_o/ada_o/din_o, cur_col_o/cur_row_o).
interface text_console_if #(
  parameter int ADDR_W = 11
);
  logic [7:0] char_i;
  logic [7:0] attr_i;
  logic valid_i;
  logic ready_o;
  logic vram_cea_o;
  logic [ADDR_W-1:0] vram_ada_o;
  logic [15:0] vram_din_o;
  logic [5:0] cur_col_o;
  logic [5:0] cur_row_o;
  modport master (
    output char_i, attr_i, valid_i,
    input ready_o, vram_cea_o, vram_ada_o, vram_din_o, cur_col_o, cur_row_o
  );
  modport slave (
    input char_i, attr_i, valid_i,
    output ready_o, vram_cea_o, vram_ada_o, vram_din_o, cur_col_o, cur_row_o
  );
endinterface

// File: rtl/text_console.sv
// text_console: turns a character/control byte stream into VRAM writes for a COLS x ROWS text grid.
// Ports: clk_i (LCD pixel / VRAM clock), rst_i (async active-high),
//        bus (slave): char_i/attr_i/valid_i/ready_o byte handshake, vram_cea_o/vram_ada_o/vram_din_o
//        VRAM write port, cur_col_o/cur_row_o cursor where the next printable lands.
module text_console #(
  parameter int COLS = 60,
  parameter int ROWS = 34,
  parameter int ADDR_W = 11,
  parameter logic [7:0] DEFAULT_ATTR = 8'h07
) (
  input logic clk_i,
  input logic rst_i,
  text_console_if.slave bus
);
  typedef enum logic [1:0] {CLR_ALL, IDLE, WRITE, CLR_LINE} state_t;
  localparam logic [ADDR_W-1:0] CELLS = ADDR_W'(COLS * ROWS);
  localparam logic [ADDR_W-1:0] NCOL = ADDR_W'(COLS);
  localparam logic [5:0] LAST_COL = 6'(COLS - 1);
  localparam logic [5:0] LAST_ROW = 6'(ROWS - 1);
  localparam logic [15:0] BLANK = {DEFAULT_ATTR, 8'h20};
  state_t state;
  logic [ADDR_W-1:0] cnt;
  logic [5:0] next_row;
  logic printable;
  // row*60 without a multiplier
  function automatic logic [ADDR_W-1:0] row_base(input logic [5:0] r);
    return (ADDR_W'(r) << 6) - (ADDR_W'(r) << 2);
  endfunction
  assign next_row = bus.cur_row_o == LAST_ROW ? 6'd0 : bus.cur_row_o + 6'd1;
  assign printable = bus.char_i >= 8'h20 && bus.char_i <= 8'h7E;
  // Outputs are registered on entry to each state, so the first write of a
  // clear is issued on the same edge that decides to start it.
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      state <= CLR_ALL;
      cnt <= '0;
      bus.ready_o <= 1'b0;
      bus.vram_cea_o <= 1'b0;
      bus.vram_ada_o <= '0;
      bus.vram_din_o <= '0;
      bus.cur_col_o <= '0;
      bus.cur_row_o <= '0;
    end else begin
      bus.vram_cea_o <= 1'b0;
      case (state)
        CLR_ALL:
          if (cnt == CELLS) begin
            state <= IDLE;
            bus.ready_o <= 1'b1;
            bus.cur_col_o <= '0;
            bus.cur_row_o <= '0;
          end else begin
            bus.vram_cea_o <= 1'b1;
            bus.vram_ada_o <= cnt;
            bus.vram_din_o <= BLANK;
            cnt <= cnt + ADDR_W'(1);
          end
        IDLE:
          if (bus.valid_i && bus.ready_o) begin
            if (printable) begin
              state <= WRITE;
              bus.ready_o <= 1'b0;
              bus.vram_cea_o <= 1'b1;
              bus.vram_ada_o <= row_base(bus.cur_row_o) + ADDR_W'(bus.cur_col_o);
              bus.vram_din_o <= {bus.attr_i, bus.char_i};
            end else if (bus.char_i == 8'h0D)
              bus.cur_col_o <= '0;
            else if (bus.char_i == 8'h0A) begin
              state <= CLR_LINE;
              bus.ready_o <= 1'b0;
              bus.cur_col_o <= '0;
              bus.cur_row_o <= next_row;
              bus.vram_cea_o <= 1'b1;
              bus.vram_ada_o <= row_base(next_row);
              bus.vram_din_o <= BLANK;
              cnt <= ADDR_W'(1);
            end else if (bus.char_i == 8'h08)
              bus.cur_col_o <= bus.cur_col_o != 6'd0 ? bus.cur_col_o - 6'd1 : bus.cur_col_o;
            else if (bus.char_i == 8'h0C) begin
              state <= CLR_ALL;
              bus.ready_o <= 1'b0;
              bus.vram_cea_o <= 1'b1;
              bus.vram_ada_o <= '0;
              bus.vram_din_o <= BLANK;
              cnt <= ADDR_W'(1);
            end
          end
        WRITE:
          if (bus.cur_col_o == LAST_COL) begin
            state <= CLR_LINE;
            bus.cur_col_o <= '0;
            bus.cur_row_o <= next_row;
            bus.vram_cea_o <= 1'b1;
            bus.vram_ada_o <= row_base(next_row);
            bus.vram_din_o <= BLANK;
            cnt <= ADDR_W'(1);
          end else begin
            state <= IDLE;
            bus.ready_o <= 1'b1;
            bus.cur_col_o <= bus.cur_col_o + 6'd1;
          end
        default:
          if (cnt == NCOL) begin
            state <= IDLE;
            bus.ready_o <= 1'b1;
          end else begin
            bus.vram_cea_o <= 1'b1;
            bus.vram_ada_o <= row_base(bus.cur_row_o) + cnt;
            bus.vram_din_o <= BLANK;
            cnt <= cnt + ADDR_W'(1);
          end
      endcase
    end
endmodule

// File: tb/tb_text_console.sv
// tb_text_console: random and directed byte streams checked cycle by cycle against a queue-based screen model.
module tb_text_console;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int n_checks = 0;
  int n_fail = 0;
  int wr_count = 0;
  int n_acc = 0;
  int mcol = 0;
  int mrow = 0;
  logic pending = 1'b1;
  logic [26:0] q[$];
  logic [10:0] last_a = '0;
  logic [15:0] last_d = '0;
  text_console_if #(.ADDR_W(11)) bus();
  text_console dut (.clk_i(clk), .rst_i(rst), .bus(bus.slave));
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  function automatic void new_line();
    mrow = (mrow + 1) % 34;
    for (int c = 0; c < 60; c++) q.push_back({11'(mrow * 60 + c), 16'h0720});
  endfunction
  function automatic void clear_all();
    for (int i = 0; i < 2040; i++) q.push_back({11'(i), 16'h0720});
    mcol = 0;
    mrow = 0;
  endfunction
  function automatic void apply(input logic [7:0] c, input logic [7:0] a);
    if (c >= 8'h20 && c <= 8'h7E) begin
      q.push_back({11'(mrow * 60 + mcol), a, c});
      mcol++;
      if (mcol == 60) begin
        mcol = 0;
        new_line();
      end
    end else if (c == 8'h0D) mcol = 0;
    else if (c == 8'h0A) begin
      mcol = 0;
      new_line();
    end else if (c == 8'h08) begin
      if (mcol > 0) mcol--;
    end else if (c == 8'h0C) clear_all();
  endfunction
  always @(posedge clk)
    if (rst) begin
      q.delete();
      pending = 1'b1;
      mcol = 0;
      mrow = 0;
    end else if (pending) begin
      clear_all();
      pending = 1'b0;
    end else if (bus.valid_i && bus.ready_o) begin
      n_acc++;
      apply(bus.char_i, bus.attr_i);
    end
  always @(negedge clk) begin
    logic busy;
    logic [26:0] e;
    if (rst) begin
      chk("rst_ready", 32'(bus.ready_o), 0);
      chk("rst_cea", 32'(bus.vram_cea_o), 0);
      chk("rst_ada", 32'(bus.vram_ada_o), 0);
      chk("rst_din", 32'(bus.vram_din_o), 0);
      chk("rst_col", 32'(bus.cur_col_o), 0);
      chk("rst_row", 32'(bus.cur_row_o), 0);
      last_a = '0;
      last_d = '0;
    end else begin
      busy = q.size() > 0;
      chk("cea", 32'(bus.vram_cea_o), 32'(busy));
      chk("ready", 32'(bus.ready_o), 32'(!busy));
      if (bus.vram_cea_o) begin
        wr_count++;
        if (busy) begin
          e = q.pop_front();
          chk("wr_addr", 32'(bus.vram_ada_o), 32'(e[26:16]));
          chk("wr_data", 32'(bus.vram_din_o), 32'(e[15:0]));
        end
        last_a = bus.vram_ada_o;
        last_d = bus.vram_din_o;
      end else begin
        chk("hold_addr", 32'(bus.vram_ada_o), 32'(last_a));
        chk("hold_data", 32'(bus.vram_din_o), 32'(last_d));
      end
      if (!busy) begin
        chk("cur_col", 32'(bus.cur_col_o), 32'(mcol));
        chk("cur_row", 32'(bus.cur_row_o), 32'(mrow));
      end
    end
  end
  task automatic send(input logic [7:0] c, input logic [7:0] a);
    int t = 0;
    int n0 = n_acc;
    bus.char_i = c;
    bus.attr_i = a;
    bus.valid_i = 1'b1;
    while (n_acc == n0 && t < 5000) begin
      @(negedge clk);
      t++;
    end
    chk("accept_timeout", 32'(n_acc != n0), 1);
    bus.valid_i = 1'b0;
  endtask
  task automatic wait_idle();
    int t = 0;
    do begin
      @(negedge clk);
      #1;
      t++;
    end while (!bus.ready_o && t < 5000);
    chk("idle_timeout", 32'(bus.ready_o), 1);
  endtask
  task automatic send_pr(input int n);
    for (int i = 0; i < n; i++) send(8'($urandom_range(32, 126)), 8'($urandom_range(0, 255)));
  endtask
  task automatic expect_pos(input string name, input int row, input int col);
    chk({name, "_row"}, 32'(bus.cur_row_o), 32'(row));
    chk({name, "_col"}, 32'(bus.cur_col_o), 32'(col));
  endtask
  initial begin
    int w0;
    logic [7:0] c;
    bus.char_i = '0;
    bus.attr_i = '0;
    bus.valid_i = 1'b0;
    repeat (3) @(negedge clk);
    #1 rst = 1'b0;
    w0 = wr_count;
    wait_idle();
    chk("boot_writes", 32'(wr_count - w0), 2040);
    chk("boot_last_addr", 32'(last_a), 2039);
    chk("boot_last_data", 32'(last_d), 32'h0720);
    expect_pos("boot", 0, 0);
    w0 = wr_count;
    send(8'h41, 8'h1F);
    #1;
    chk("a_cea_n1", 32'(bus.vram_cea_o), 1);
    chk("a_ready_n1", 32'(bus.ready_o), 0);
    chk("a_addr", 32'(bus.vram_ada_o), 0);
    chk("a_data", 32'(bus.vram_din_o), 32'h1F41);
    @(negedge clk);
    #1;
    chk("a_ready_n2", 32'(bus.ready_o), 1);
    chk("a_writes", 32'(wr_count - w0), 1);
    expect_pos("a", 0, 1);
    w0 = wr_count;
    send(8'h0D, 8'h00);
    wait_idle();
    expect_pos("cr1", 0, 0);
    send_pr(60);
    wait_idle();
    chk("line_writes", 32'(wr_count - w0), 120);
    chk("line_last_addr", 32'(last_a), 119);
    chk("line_last_data", 32'(last_d), 32'h0720);
    expect_pos("wrap", 1, 0);
    repeat (32) send(8'h0A, 8'h00);
    send_pr(5);
    wait_idle();
    expect_pos("r33", 33, 5);
    w0 = wr_count;
    send(8'h0A, 8'h00);
    wait_idle();
    chk("lf_wrap_writes", 32'(wr_count - w0), 60);
    chk("lf_wrap_last", 32'(last_a), 59);
    expect_pos("lf_wrap", 0, 0);
    send_pr(7);
    wait_idle();
    expect_pos("c7", 0, 7);
    w0 = wr_count;
    send(8'h0D, 8'h00);
    send(8'h08, 8'h00);
    wait_idle();
    chk("cr_bs_writes", 32'(wr_count - w0), 0);
    expect_pos("bs0", 0, 0);
    send_pr(3);
    send(8'h08, 8'h00);
    wait_idle();
    expect_pos("bs3", 0, 2);
    w0 = wr_count;
    send(8'h01, 8'h55);
    send(8'h7F, 8'h55);
    wait_idle();
    chk("ign_writes", 32'(wr_count - w0), 0);
    expect_pos("ign", 0, 2);
    send(8'h0D, 8'h00);
    repeat (10) send(8'h0A, 8'h00);
    send_pr(10);
    wait_idle();
    expect_pos("r10", 10, 10);
    w0 = wr_count;
    send(8'h0C, 8'h00);
    wait_idle();
    chk("ff_writes", 32'(wr_count - w0), 2040);
    expect_pos("ff", 0, 0);
    for (int i = 0; i < 300; i++) begin
      int r = $urandom_range(0, 99);
      if (r < 75) c = 8'($urandom_range(32, 126));
      else if (r < 82) c = 8'h0A;
      else if (r < 88) c = 8'h0D;
      else if (r < 94) c = 8'h08;
      else
        do c = 8'($urandom_range(0, 255));
        while ((c >= 8'h20 && c <= 8'h7E) || c == 8'h0A || c == 8'h0D || c == 8'h08 || c == 8'h0C);
      send(c, 8'($urandom_range(0, 255)));
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    wait_idle();
    w0 = wr_count;
    send(8'h0C, 8'h00);
    for (int t = 0; t < 5000 && wr_count - w0 < 499; t++) @(posedge clk);
    #2;
    chk("mid_cea", 32'(bus.vram_cea_o), 1);
    chk("mid_addr", 32'(bus.vram_ada_o), 499);
    rst = 1'b1;
    #1;
    chk("async_cea", 32'(bus.vram_cea_o), 0);
    chk("async_ready", 32'(bus.ready_o), 0);
    repeat (2) @(negedge clk);
    #1 rst = 1'b0;
    w0 = wr_count;
    wait_idle();
    chk("restart_writes", 32'(wr_count - w0), 2040);
    expect_pos("restart", 0, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/text_console.md
# text_console

Upstream feeder for the text-mode video block: accepts a byte stream of characters and control codes over a valid/ready handshake and turns it into VRAM write cycles for the 60x34 character grid. It tracks the cursor, handles newline, carriage return, backspace, form feed and wrap-around, and clears rows as the cursor enters them. It replaces the free-running LFSR pattern filler and drives the video block's VRAM write port (enable, address, data) directly on the same clock.

## Interface
- COLS, 60, characters per row
- ROWS, 34, rows per screen
- ADDR_W, 11, VRAM address width (COLS*ROWS = 2040 cells)
- DEFAULT_ATTR, 8'h07, attribute used for blank cells written by clears

- clk_i  in  1  block clock (LCD pixel clock, also VRAM write clock)
- rst_i  in  1  reset, asynchronous, active-high
- char_i  in  8  character or control code
- attr_i  in  8  attribute for char_i: {bg[3:0], fg[3:0]}, CGA colours
- valid_i  in  1  char_i/attr_i valid
- ready_o  out  1  block can accept a byte this cycle
- vram_cea_o  out  1  VRAM write enable, active-high, one cycle per cell
- vram_ada_o  out  ADDR_W  VRAM cell address, row*COLS + col
- vram_din_o  out  16  VRAM word {attr[7:0], char[7:0]}
- cur_col_o  out  6  cursor column 0..COLS-1
- cur_row_o  out  6  cursor row 0..ROWS-1

## Operation
- States: CLR_ALL, IDLE, WRITE, CLR_LINE.
- Reset: all outputs 0 (ready_o=0, vram_cea_o=0, vram_ada_o=0, vram_din_o=0, cursor 0,0). FSM enters CLR_ALL as reset releases.
- CLR_ALL: writes {DEFAULT_ATTR, 8'h20} to addresses 0..COLS*ROWS-1 in ascending order, one per cycle. Then cursor (0,0) -> IDLE.
- IDLE: ready_o=1. Transfer occurs when valid_i && ready_o. Decode:
  - 0x20..0x7E: latch char/attr -> WRITE.
  - 0x0D (CR): col=0, no write, stay IDLE.
  - 0x0A (LF): col=0, row advance -> CLR_LINE.
  - 0x08 (BS): col=col-1 if col>0, else unchanged. No write, no row change.
  - 0x0C (FF): -> CLR_ALL.
  - Any other code: consumed, no effect.
- WRITE: one write of {attr, char} at the cursor. If col<COLS-1: col+1 -> IDLE. If col==COLS-1: col=0, row advance -> CLR_LINE.
- Row advance: row+1, or 0 when row==ROWS-1 (wrap, no scrolling).
- CLR_LINE: writes {DEFAULT_ATTR, 8'h20} to the COLS cells of the new cursor row, ascending col. Then -> IDLE.
- Address arithmetic: row*60 computed as (row<<6) - (row<<2), 11-bit unsigned. Never exceeds 2039.
- ready_o=0 in every state except IDLE. valid_i is ignored there, and the producer holds the byte.

## Timing
- All outputs are registered. The VRAM port sees vram_cea_o/ada/din change together on a clk_i edge.
- Printable byte accepted at edge N: write visible in cycle N+1 (vram_cea_o=1 for exactly one cycle). ready_o returns high in cycle N+2. Sustained throughput is 1 char per 2 cycles.
- CR, BS, ignored codes: ready_o stays high and the next byte can be accepted the next cycle. Cursor outputs update one cycle after acceptance.
- LF: CLR_LINE starts in cycle N+1 and lasts COLS cycles. ready_o is low for COLS cycles.
- Auto-wrap: WRITE cycle, then COLS clear cycles. ready_o is low for 1+COLS cycles.
- CLR_ALL after reset or FF: 2040 write cycles, then ready_o=1 in the following cycle.
- vram_cea_o=0 in IDLE. vram_ada_o/vram_din_o hold their last values when not writing.
- Reset asserted mid-WRITE/CLR_LINE/CLR_ALL: outputs go to reset values immediately (asynchronous). The partial operation is abandoned and the full clear restarts after release.
- Cursor outputs reflect the position where the next printable character will be written.

## Test plan
- Reset release: exactly 2040 writes, addr 0..2039, data 0x0720, contiguous cycles. Then ready_o=1, cursor (0,0).
- Send 'A' with attr 0x1F: one write, addr 0, data 0x1F41, one cycle after acceptance. Cursor (0,1), ready_o high 2 cycles after acceptance.
- Send 60 printable bytes from (0,0): writes at addresses 0..59, then 60 clear writes at addresses 60..119 with data 0x0720. Cursor ends at (1,0).
- Cursor at (33,5), send LF: clear writes at addresses 0..59, cursor (0,0). Send CR at col 7: col=0, no write. Send BS at col 0: no change.
- Send 0x01 and 0x7F: no writes, cursor unchanged, ready_o stays 1. Send FF from (10,10): 2040 clear writes, cursor (0,0).
- Assert rst_i during the 500th write of CLR_ALL: vram_cea_o=0 and ready_o=0 the same cycle. After release, the clear restarts at address 0.
